uart_rx_fifo_echo: RTL and testbench
====================================

// Module: uart_rx_fifo_echo
// PURPOSE
// Parametrised UART endpoint for the game's serial keyboard link: oversampled receiver, RX FIFO, transmitter.
// Received bytes are queued for the game logic, which pops them through a valid/ready port.
// With ECHO=1, each accepted byte is also retransmitted to the host.
// Replaces the fixed 8-bit, unbuffered, edge-triggered echo path; adds frame/overrun error reporting.
// PARAMETERS
// CLK_HZ      100_000_000  system clock frequency
// BAUD        9600         line rate
// OVERSAMPLE  16           ticks per bit; even, >=8
// DATA_BITS   8            payload bits per frame (5..9)
// FIFO_DEPTH  8            RX FIFO entries; power of 2, >=2
// ECHO        1            1: accepted RX bytes are retransmitted; 0: TX driven by tx_* port
// PORTS
// clk         in   1              system clock; all logic on posedge
// rst_n       in   1              asynchronous, active-low reset
// rx          in   1              serial input (asynchronous, idle high)
// tx          out  1              serial output (idle high)
// rx_data     out  DATA_BITS      FIFO head byte; valid when rx_valid=1
// rx_valid    out  1              FIFO not empty
// rx_ready    in   1              consumer pops head when rx_valid&rx_ready
// rx_count    out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
// tx_data     in   DATA_BITS      byte to send (used only when ECHO=0)
// tx_valid    in   1              send request (ECHO=0)
// tx_ready    out  1              transmitter idle; constant 0 when ECHO=1
// frame_err   out  1              1-cycle pulse: stop bit sampled low
// overrun     out  1              1-cycle pulse: byte dropped, FIFO full
// echo_drop   out  1              1-cycle pulse: echo skipped, TX busy (ECHO=1)
// BEHAVIOUR
// - Reset (async): tx=1, rx_valid=0, rx_data=0, rx_count=0, all pulses 0, tx_ready=!ECHO; FSMs to IDLE; FIFO empty.
// - Tick gen: DIV=CLK_HZ/(BAUD*OVERSAMPLE), integer floor. Counter runs 0..DIV-1; tick=1 for one clk at DIV-1.
// - rx passes a 2-FF synchroniser before use; initialise both FFs to 1.
// - RX FSM IDLE->START on synced rx=0 at a tick. START: at tick OVERSAMPLE/2-1 (mid-bit), rx=1 -> IDLE (glitch, nothing reported).
//   Otherwise -> DATA.
// - DATA: sample every OVERSAMPLE ticks, LSB first, DATA_BITS samples -> STOP.
// - STOP: sample after OVERSAMPLE ticks.
//   - Sample 0: frame_err pulse, byte discarded.
//   - Sample 1: byte accepted.
//   Either way -> IDLE. After a frame error, IDLE waits until rx=1 before re-arming.
// - Accept: push on the clk after stop sample. rx_valid/rx_data reflect it the following clk.
//   FIFO is show-ahead: rx_data=head combinationally from storage.
// - Full: push with rx_count==FIFO_DEPTH and no pop that cycle -> byte dropped, overrun pulse, FIFO unchanged.
//   Push and pop in the same cycle when full: both succeed, count unchanged.
// - Empty: rx_ready with rx_valid=0 is ignored. Pointers wrap modulo FIFO_DEPTH.
// - TX FSM IDLE/START/DATA/STOP, each bit OVERSAMPLE ticks. Sends start 0, DATA_BITS LSB first, one stop 1. Returns to IDLE.
// - ECHO=0: load tx_data when tx_valid&tx_ready; tx_ready drops the next clk and rises after the stop bit ends.
// - ECHO=1: an accepted byte loads TX if TX is IDLE; otherwise echo_drop pulses. The FIFO push is unaffected.
// - Reset mid-frame: both FSMs abort immediately, tx=1, partial byte lost.
// TESTING  (CLK_HZ=1_600_000, BAUD=10_000, OVERSAMPLE=16 -> DIV=10, bit=160 clk; DATA_BITS=8, FIFO_DEPTH=4)
// 1. Frame 0x57, rx_ready=0 -> rx_valid=1, rx_data=0x57, rx_count=1. ECHO=1: tx shows 0,1,1,1,0,1,0,1,0,1 at 160 clk/bit.
// 2. Send 5 bytes 0x01..0x05, rx_ready=0 -> rx_count=4, one overrun pulse on 5th byte; pops return 01,02,03,04, then rx_valid=0.
// 3. Frame 0xA5 with stop bit 0 -> frame_err pulse, rx_count stays 0; next good frame 0x3C is received correctly.
// 4. 40-clk low glitch on rx -> no frame_err, no push, RX back in IDLE.
// 5. ECHO=1, two back-to-back frames 0x11,0x22 -> both in FIFO; 0x22 echo skipped with echo_drop pulse.
// 6. ECHO=0, tx_valid with 0xC3 -> tx_ready=0 for 1600 clk, correct waveform. Assert rst_n=0 mid-frame -> tx=1, rx_count=0 at once.

Source files
------------

// File: rtl/uart_rx_fifo_echo.sv
// UART endpoint: oversampled receiver feeding a show-ahead RX FIFO, plus a transmitter
// that either echoes accepted bytes (ECHO=1) or serves the tx_* request port (ECHO=0).
`timescale 1ns/1ps
module uart_rx_fifo_echo #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int ECHO       = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx,
    output logic                          tx,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          frame_err,
    output logic                          overrun,
    output logic                          echo_drop
);
    localparam int DIV = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OW  = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(DATA_BITS + 1);
    localparam int AW  = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    // tx_* inputs are ignored in echo mode
    logic unused_tx_in;
    assign unused_tx_in = ^{tx_data, tx_valid};

    logic [DW-1:0] div_q;
    logic          tick;
    assign tick = (div_q == DW'(DIV - 1));

    logic [1:0] sync_q;
    logic       rx_s;
    assign rx_s = sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= '0;
            sync_q <= 2'b11;
        end else begin
            div_q  <= tick ? '0 : div_q + 1'b1;
            sync_q <= {sync_q[0], rx};
        end
    end

    rx_state_t              rx_state_q, rx_state_d;
    logic [OW-1:0]          rx_os_q, rx_os_d;
    logic [BW-1:0]          rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0]   rx_sh_q, rx_sh_d;
    logic                   push_q, push_d;
    logic                   ferr_q, ferr_d;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_os_d    = rx_os_q;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        push_d     = 1'b0;
        ferr_d     = 1'b0;
        case (rx_state_q)
            RX_IDLE: if (tick && !rx_s) begin
                rx_state_d = RX_START;
                rx_os_d    = '0;
            end
            RX_START: if (tick) begin
                if (rx_os_q == OW'(OVERSAMPLE / 2 - 1)) begin
                    rx_os_d    = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    rx_os_d = rx_os_q + 1'b1;
                end
            end
            RX_DATA: if (tick) begin
                if (rx_os_q == OW'(OVERSAMPLE - 1)) begin
                    rx_os_d = '0;
                    rx_sh_d = {rx_s, rx_sh_q[DATA_BITS-1:1]};
                    if (rx_bit_q == BW'(DATA_BITS - 1)) rx_state_d = RX_STOP;
                    else                                rx_bit_d   = rx_bit_q + 1'b1;
                end else begin
                    rx_os_d = rx_os_q + 1'b1;
                end
            end
            RX_STOP: if (tick) begin
                if (rx_os_q == OW'(OVERSAMPLE - 1)) begin
                    rx_os_d = '0;
                    if (rx_s) begin
                        push_d     = 1'b1;
                        rx_state_d = RX_IDLE;
                    end else begin
                        ferr_d     = 1'b1;
                        rx_state_d = RX_WAIT;
                    end
                end else begin
                    rx_os_d = rx_os_q + 1'b1;
                end
            end
            // a broken frame may leave the line low; re-arm only once it idles high
            RX_WAIT: if (rx_s) rx_state_d = RX_IDLE;
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q <= RX_IDLE;
            rx_os_q    <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            push_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_os_q    <= rx_os_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            push_q     <= push_d;
            ferr_q     <= ferr_d;
        end
    end

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_q, rd_q;
    logic [AW:0]          cnt_q;
    logic                 pop, full, do_push, ovr_q;

    assign pop     = rx_ready && rx_valid;
    assign full    = (cnt_q == (AW+1)'(FIFO_DEPTH));
    assign do_push = push_q && (!full || pop);

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= rx_sh_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            ovr_q <= 1'b0;
        end else begin
            ovr_q <= push_q && full && !pop;
            if (do_push) wr_q <= wr_q + 1'b1;
            if (pop)     rd_q <= rd_q + 1'b1;
            case ({do_push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign rx_valid  = (cnt_q != '0);
    assign rx_data   = rx_valid ? mem_q[rd_q] : '0;
    assign rx_count  = cnt_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;

    tx_state_t            tx_state_q, tx_state_d;
    logic [DW-1:0]        tx_div_q, tx_div_d;
    logic [OW-1:0]        tx_os_q, tx_os_d;
    logic [BW-1:0]        tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
    logic                 drop_q, drop_d;
    logic                 tx_idle, tx_tick, load;
    logic [DATA_BITS-1:0] load_data;

    assign tx_idle = (tx_state_q == TX_IDLE);
    // private divider restarted on load so every bit is exactly DIV*OVERSAMPLE clocks
    assign tx_tick = (tx_div_q == DW'(DIV - 1));

    always_comb begin
        load      = 1'b0;
        load_data = tx_data;
        drop_d    = 1'b0;
        if (ECHO != 0) begin
            load      = push_q && tx_idle;
            load_data = rx_sh_q;
            drop_d    = push_q && !tx_idle;
        end else begin
            load      = tx_valid && tx_idle;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_os_d    = tx_os_q;
        tx_bit_d   = tx_bit_q;
        tx_sh_d    = tx_sh_q;
        tx_div_d   = (tx_idle || tx_tick) ? '0 : tx_div_q + 1'b1;
        case (tx_state_q)
            TX_IDLE: if (load) begin
                tx_state_d = TX_START;
                tx_os_d    = '0;
                tx_sh_d    = load_data;
            end
            TX_START: if (tx_tick) begin
                if (tx_os_q == OW'(OVERSAMPLE - 1)) begin
                    tx_os_d    = '0;
                    tx_bit_d   = '0;
                    tx_state_d = TX_DATA;
                end else begin
                    tx_os_d = tx_os_q + 1'b1;
                end
            end
            TX_DATA: if (tx_tick) begin
                if (tx_os_q == OW'(OVERSAMPLE - 1)) begin
                    tx_os_d = '0;
                    tx_sh_d = tx_sh_q >> 1;
                    if (tx_bit_q == BW'(DATA_BITS - 1)) tx_state_d = TX_STOP;
                    else                                tx_bit_d   = tx_bit_q + 1'b1;
                end else begin
                    tx_os_d = tx_os_q + 1'b1;
                end
            end
            TX_STOP: if (tx_tick) begin
                if (tx_os_q == OW'(OVERSAMPLE - 1)) begin
                    tx_os_d    = '0;
                    tx_state_d = TX_IDLE;
                end else begin
                    tx_os_d = tx_os_q + 1'b1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= TX_IDLE;
            tx_div_q   <= '0;
            tx_os_q    <= '0;
            tx_bit_q   <= '0;
            tx_sh_q    <= '0;
            drop_q     <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_div_q   <= tx_div_d;
            tx_os_q    <= tx_os_d;
            tx_bit_q   <= tx_bit_d;
            tx_sh_q    <= tx_sh_d;
            drop_q     <= drop_d;
        end
    end

    always_comb begin
        tx = 1'b1;
        case (tx_state_q)
            TX_START: tx = 1'b0;
            TX_DATA:  tx = tx_sh_q[0];
            default:  tx = 1'b1;
        endcase
    end

    assign tx_ready  = (ECHO == 0) && tx_idle;
    assign echo_drop = drop_q;
endmodule

// File: tb/tb_uart_rx_fifo_echo.sv
// Directed bench for uart_rx_fifo_echo: an echo instance and a plain-TX instance share
// clock and reset; byte scoreboards hold expected FIFO output and expected echoed frames.
`timescale 1ns/1ps
module tb_uart_rx_fifo_echo;
    localparam int BIT = 160;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       rx_e = 1'b1, rx_ready_e = 1'b0;
    logic       tx_e, rx_valid_e, tx_ready_e, fe_e, ovr_e, drop_e;
    logic [7:0] rx_data_e;
    logic [2:0] rx_count_e;
    logic [7:0] tx_data_e = 8'h00;
    logic       tx_valid_e = 1'b0;

    logic       rx_n = 1'b1, rx_ready_n = 1'b0;
    logic       tx_n, rx_valid_n, tx_ready_n, fe_n, ovr_n, drop_n;
    logic [7:0] rx_data_n;
    logic [2:0] rx_count_n;
    logic [7:0] tx_data_n = 8'h00;
    logic       tx_valid_n = 1'b0;

    uart_rx_fifo_echo #(.CLK_HZ(1_600_000), .BAUD(10_000), .OVERSAMPLE(16),
                        .DATA_BITS(8), .FIFO_DEPTH(4), .ECHO(1)) dut_e (
        .clk(clk), .rst_n(rst_n), .rx(rx_e), .tx(tx_e),
        .rx_data(rx_data_e), .rx_valid(rx_valid_e), .rx_ready(rx_ready_e), .rx_count(rx_count_e),
        .tx_data(tx_data_e), .tx_valid(tx_valid_e), .tx_ready(tx_ready_e),
        .frame_err(fe_e), .overrun(ovr_e), .echo_drop(drop_e));

    uart_rx_fifo_echo #(.CLK_HZ(1_600_000), .BAUD(10_000), .OVERSAMPLE(16),
                        .DATA_BITS(8), .FIFO_DEPTH(4), .ECHO(0)) dut_n (
        .clk(clk), .rst_n(rst_n), .rx(rx_n), .tx(tx_n),
        .rx_data(rx_data_n), .rx_valid(rx_valid_n), .rx_ready(rx_ready_n), .rx_count(rx_count_n),
        .tx_data(tx_data_n), .tx_valid(tx_valid_n), .tx_ready(tx_ready_n),
        .frame_err(fe_n), .overrun(ovr_n), .echo_drop(drop_n));

    int n_assert = 0;
    int n_fail   = 0;
    int fe_cnt = 0, ovr_cnt = 0, drop_cnt = 0;
    int exp_ovr = 0;
    logic [7:0] rx_sb[$];
    logic [7:0] tx_sb[$];

    always @(negedge clk) begin
        if (rst_n) begin
            fe_cnt   += fe_e   ? 1 : 0;
            ovr_cnt  += ovr_e  ? 1 : 0;
            drop_cnt += drop_e ? 1 : 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_head(input logic [7:0] b);
        rx_e = 1'b0;
        wait_clk(BIT);
        for (int i = 0; i < 8; i++) begin
            rx_e = b[i];
            wait_clk(BIT);
        end
    endtask

    // full frame; a good stop bit enters the scoreboard or counts as an expected overrun
    task automatic send_frame(input logic [7:0] b, input logic stop);
        send_head(b);
        rx_e = stop;
        if (stop) begin
            if (rx_sb.size() < 4) rx_sb.push_back(b);
            else                  exp_ovr++;
        end
        wait_clk(BIT);
        rx_e = 1'b1;
    endtask

    task automatic pop_check(input string tag);
        logic [7:0] exp;
        exp = (rx_sb.size() > 0) ? rx_sb.pop_front() : 8'h00;
        @(negedge clk);
        check({tag, "_valid"}, rx_valid_e, 1'b1);
        check({tag, "_data"}, rx_data_e, exp);
        rx_ready_e = 1'b1;
        @(negedge clk);
        rx_ready_e = 1'b0;
    endtask

    task automatic echo_check(input string tag);
        logic [9:0] frame;
        logic [7:0] b;
        int         found;
        b = (tx_sb.size() > 0) ? tx_sb.pop_front() : 8'h00;
        frame = {1'b1, b, 1'b0};
        found = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (tx_e == 1'b0) begin
                found = 1;
                break;
            end
        end
        check({tag, "_start_seen"}, found, 1);
        wait_clk(BIT / 2);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("%s_bit%0d", tag, i), tx_e, frame[i]);
            if (i < 9) wait_clk(BIT);
        end
    endtask

    initial begin
        int base;
        int busy;
        logic [9:0] nframe;

        #23;
        check("rst_tx", tx_e, 1'b1);
        check("rst_rx_valid", rx_valid_e, 1'b0);
        check("rst_rx_data", rx_data_e, 8'h00);
        check("rst_rx_count", rx_count_e, 3'd0);
        check("rst_tx_ready_echo", tx_ready_e, 1'b0);
        check("rst_tx_ready_plain", tx_ready_n, 1'b1);
        check("rst_pulses", {fe_e, ovr_e, drop_e}, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        wait_clk(20);

        // 1: single frame with echo
        send_head(8'h57);
        rx_e = 1'b1;
        rx_sb.push_back(8'h57);
        tx_sb.push_back(8'h57);
        echo_check("t1_echo");
        check("t1_count", rx_count_e, 3'd1);
        pop_check("t1_pop");
        @(negedge clk);
        check("t1_empty", rx_valid_e, 1'b0);
        wait_clk(200);

        // 2: overflow
        base = ovr_cnt;
        exp_ovr = 0;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
        wait_clk(20);
        check("t2_count", rx_count_e, 3'd4);
        check("t2_overrun", ovr_cnt - base, exp_ovr);
        for (int i = 0; i < 4; i++) pop_check($sformatf("t2_pop%0d", i));
        @(negedge clk);
        check("t2_empty", rx_valid_e, 1'b0);
        check("t2_count0", rx_count_e, 3'd0);
        wait_clk(2000);

        // 3: frame error then recovery
        base = fe_cnt;
        send_frame(8'hA5, 1'b0);
        wait_clk(40);
        check("t3_frame_err", fe_cnt - base, 1);
        check("t3_count", rx_count_e, 3'd0);
        send_frame(8'h3C, 1'b1);
        wait_clk(10);
        pop_check("t3_pop");

        // 4: short glitch on the line
        base = fe_cnt;
        rx_e = 1'b0;
        wait_clk(40);
        rx_e = 1'b1;
        wait_clk(300);
        check("t4_no_ferr", fe_cnt - base, 0);
        check("t4_no_push", rx_count_e, 3'd0);
        send_frame(8'h5A, 1'b1);
        wait_clk(10);
        pop_check("t4_after");
        wait_clk(2000);

        // 5: back-to-back frames, second echo must be dropped
        base = drop_cnt;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        wait_clk(20);
        check("t5_echo_drop", drop_cnt - base, 1);
        check("t5_count", rx_count_e, 3'd2);
        pop_check("t5_pop0");
        pop_check("t5_pop1");
        wait_clk(2000);

        // 6: plain transmitter
        nframe = {1'b1, 8'hC3, 1'b0};
        @(negedge clk);
        check("t6_ready_before", tx_ready_n, 1'b1);
        tx_data_n  = 8'hC3;
        tx_valid_n = 1'b1;
        @(negedge clk);
        tx_valid_n = 1'b0;
        busy = 0;
        for (int k = 0; k < 2000; k++) begin
            if (tx_ready_n) break;
            if (k % BIT == BIT / 2) check($sformatf("t6_bit%0d", k / BIT), tx_n, nframe[k / BIT]);
            busy++;
            @(negedge clk);
        end
        check("t6_busy_clks", busy, 1600);
        wait_clk(10);

        // 6b: reset in the middle of traffic
        send_frame(8'h99, 1'b1);
        wait_clk(10);
        check("t6_rx_before_rst", rx_count_e, 3'd1);
        tx_valid_n = 1'b1;
        @(negedge clk);
        tx_valid_n = 1'b0;
        wait_clk(499);
        check("t6_tx_mid_low", tx_n, 1'b0);
        #2;
        rst_n = 1'b0;
        rx_sb.delete();
        #1;
        check("t6_rst_tx", tx_n, 1'b1);
        check("t6_rst_count", rx_count_e, 3'd0);
        check("t6_rst_valid", rx_valid_e, 1'b0);
        check("t6_rst_ready", tx_ready_n, 1'b1);
        wait_clk(5);
        rst_n = 1'b1;
        wait_clk(20);
        check("t6_idle_after", {tx_e, tx_n}, 2'b11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
